// File: rtl/ddram_responder.sv
// ddram_responder: memory end of the 64-bit DDRAM port, backed by a 2^ADDR_W x 64 on-chip array.
// Latency: write beats land at the accepting edge; read beats start RD_LATENCY cycles after acceptance.
// Backpressure: BUSY is held for the whole read and pulsed periodically in IDLE/WRITE when BUSY_PERIOD>0.
module ddram_responder #(
    parameter int ADDR_W      = 10,
    parameter int RD_LATENCY  = 2,
    parameter int BUSY_PERIOD = 0
) (
    input  logic        DDRAM_CLK,
    input  logic        reset_n,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    input  logic        DDRAM_RD,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    input  logic        DDRAM_WE,
    output logic        proto_err
);

    localparam int LAT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam int CNT_W = (BUSY_PERIOD > 2) ? $clog2(BUSY_PERIOD) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'((RD_LATENCY > 1) ? RD_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'((BUSY_PERIOD > 0) ? BUSY_PERIOD - 1 : 0);
    localparam bit INJECT = (BUSY_PERIOD > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_DATA
    } state_t;

    logic [63:0]       mem [0:(1<<ADDR_W)-1];
    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        remaining;
    logic [7:0]        count;
    logic [7:0]        eff_len;
    logic [LAT_W-1:0]  lat;
    logic [CNT_W-1:0]  busy_cnt;
    logic              rd_phase;
    logic              busy_inj;
    logic              wr_en;
    logic              rd_accept;
    logic              beat;
    logic              err_set;
    logic              unused_addr;

    // Upper address bits are deliberately not decoded.
    assign unused_addr = ^DDRAM_ADDR[28:ADDR_W];

    // A burst count of zero behaves as a single beat.
    assign eff_len  = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    assign rd_phase = (state == ST_RD_WAIT) || (state == ST_RD_DATA);
    assign busy_inj = INJECT && !rd_phase && (busy_cnt == BUSY_LAST);
    assign DDRAM_BUSY = rd_phase || busy_inj;

    // Next state and per-cycle strobes; nothing is accepted while BUSY is high.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = waddr;
        rd_accept = 1'b0;
        beat      = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!DDRAM_BUSY) begin
                    if (DDRAM_WE) begin
                        // Write wins a simultaneous read; the read is dropped and flagged.
                        wr_en   = 1'b1;
                        wr_addr = DDRAM_ADDR[ADDR_W-1:0];
                        err_set = DDRAM_RD;
                        if (eff_len != 8'd1) begin
                            state_nxt = ST_WRITE;
                        end
                    end else if (DDRAM_RD) begin
                        rd_accept = 1'b1;
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                if (!DDRAM_BUSY) begin
                    err_set = DDRAM_RD;
                    if (DDRAM_WE) begin
                        wr_en = 1'b1;
                        if (remaining == 8'd1) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                // The edge leaving RD_WAIT already registers the first beat.
                if (lat == '0) begin
                    beat      = 1'b1;
                    state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                // Stay here (BUSY high) while the last beat is on the bus.
                if (count != 8'd0) begin
                    beat = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst bookkeeping, registered read data, sticky error and wait-state counter.
    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            waddr            <= '0;
            raddr            <= '0;
            remaining        <= 8'd0;
            count            <= 8'd0;
            lat              <= '0;
            busy_cnt         <= '0;
            DDRAM_DOUT       <= 64'd0;
            DDRAM_DOUT_READY <= 1'b0;
            proto_err        <= 1'b0;
        end else begin
            if (wr_en) begin
                waddr     <= wr_addr + 1'b1;
                remaining <= (state == ST_IDLE) ? eff_len - 8'd1 : remaining - 8'd1;
            end
            if (rd_accept) begin
                raddr <= DDRAM_ADDR[ADDR_W-1:0];
                count <= eff_len;
                lat   <= LAT_INIT;
            end else if (beat) begin
                raddr <= raddr + 1'b1;
                count <= count - 8'd1;
            end
            if (state == ST_RD_WAIT && lat != '0) begin
                lat <= lat - 1'b1;
            end
            DDRAM_DOUT_READY <= beat;
            if (beat) begin
                DDRAM_DOUT <= mem[raddr];
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (INJECT && !rd_phase) begin
                busy_cnt <= busy_inj ? '0 : busy_cnt + 1'b1;
            end
        end
    end

    // Byte-enabled array write; contents survive reset, but no writes land while reset is held.
    always_ff @(posedge DDRAM_CLK) begin
        if (wr_en && reset_n) begin
            for (int i = 0; i < 8; i++) begin
                if (DDRAM_BE[i]) begin
                    mem[wr_addr][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ddram_responder.md
Name: ddram_responder

Overview:
- Avalon-MM-style responder for the DDRAM_* port: the memory end of the 64-bit DDRAM interface that core-side DDR3 masters drive.
- Backed by an on-chip array of 2^ADDR_W 64-bit words.
- Used in simulation and in BRAM-only builds in place of the HPS DDR3 bridge.
- Supports burst reads with fixed latency, byte-enabled burst writes and programmable wait-state injection, so masters can be exercised against realistic BUSY behaviour.

Parameters:
ADDR_W, 10, word-address width of the backing array; only DDRAM_ADDR[ADDR_W-1:0] is decoded, upper bits ignored
RD_LATENCY, 2, cycles from read-command acceptance to first DDRAM_DOUT_READY beat (minimum 1)
BUSY_PERIOD, 0, 0 = no injected wait states; N>0 = BUSY forced high for one cycle every N cycles while IDLE or WRITE

Ports:
DDRAM_CLK  in  1  single clock
reset_n  in  1  asynchronous active-low reset
DDRAM_BUSY  out  1  waitrequest; a command or write beat is accepted only in a cycle where BUSY=0
DDRAM_BURSTCNT  in  8  burst length, sampled on the first accepted beat; 0 is treated as 1
DDRAM_ADDR  in  29  64-bit word address, sampled on the first accepted beat
DDRAM_DOUT  out  64  read data
DDRAM_DOUT_READY  out  1  read data valid, one beat per cycle
DDRAM_RD  in  1  read request
DDRAM_DIN  in  64  write data
DDRAM_BE  in  8  per-byte write enables
DDRAM_WE  in  1  write request
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; BUSY=0; DOUT_READY=0; DOUT=0; proto_err=0.
  - Busy-injection counter cleared.
  - Array contents are NOT cleared.
  - Reset mid-burst aborts the burst: no further beats are written or returned.
- Wait-state injection:
  - Counter runs in IDLE and WRITE.
  - When it reaches BUSY_PERIOD-1, BUSY=1 for that cycle and the counter wraps to 0.
  - Inputs are ignored in a busy cycle; the master must hold them.
- States:
  - IDLE:
    - WE&!BUSY: write DIN into mem[ADDR] under BE (byte i written iff BE[i]); remaining=BURSTCNT-1 (0 treated as 1); waddr=ADDR+1; go to WRITE if remaining>0, else stay IDLE.
    - RD&!BUSY (WE=0): raddr=ADDR; count=BURSTCNT (0 treated as 1); lat=RD_LATENCY-1; go to RD_WAIT.
    - RD&WE in the same accepted cycle: the write wins, the read is dropped, proto_err set.
  - WRITE:
    - Each cycle with WE&!BUSY: write beat to mem[waddr] under BE; waddr++; remaining--; return to IDLE when remaining reaches 0.
    - RD asserted in WRITE with !BUSY: proto_err set, RD ignored.
  - RD_WAIT:
    - BUSY=1.
    - lat decrements each cycle; at 0 go to RD_DATA.
  - RD_DATA:
    - BUSY=1.
    - Each cycle: DOUT=mem[raddr], DOUT_READY=1, raddr++, count--.
    - After the last beat go to IDLE; DOUT_READY=0 the next cycle.
- Address arithmetic:
  - raddr and waddr are ADDR_W bits and wrap modulo 2^ADDR_W within a burst.
- Array read:
  - Synchronous, registered.
  - RD_LATENCY counts from the acceptance edge to the first cycle DOUT_READY is high.
  - With RD_LATENCY=2: command accepted at edge k, first beat valid after edge k+2, beats contiguous.
- Read-after-write:
  - A read accepted the cycle after the final write beat returns the new data; the implementation must not use a stale read port.
- Injection never interrupts RD_WAIT or RD_DATA; BUSY is already 1 there.

Test Plan:
- Single write, read-back: WE addr 0x30000010, DIN 0x1122334455667788, BE 0xFF, BURSTCNT 1; then RD addr 0x30000010, BURSTCNT 1 -> one DOUT_READY beat 2 cycles after acceptance, DOUT=0x1122334455667788.
- Byte enables: prefill word 5 with 0; WE DIN 0xFFFFFFFFFFFFFFFF, BE 0x0C -> read word 5 = 0x00000000FFFF0000.
- Read burst of 2 from words 0x3FF,0x000 (ADDR_W=10, prefilled with A and B) -> two consecutive beats A then B (wrap); BUSY=1 from acceptance until after the last beat.
- Write burst: BURSTCNT 4 at word 8, data 1..4, with BUSY_PERIOD=3 -> master holds data through busy cycles; words 8..11 = 1,2,3,4; BUSY pulses every 3rd cycle.
- RD and WE asserted together in IDLE -> write performed, no DOUT_READY, proto_err=1 and stays 1 until reset.
- reset_n low during RD_DATA of an 8-beat burst after 3 beats -> DOUT_READY drops immediately, state IDLE, previously written array data intact on re-read.
